// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: sequences the shared comparator for one branch at a time,
// resolves the outcome and requests a fetch redirect on mispredict. Optional BRANCH_STATS_EN adds counters.
module branch_resolve_ctrl #(
    parameter int VAR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef BRANCH_STATS_EN
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts,
`endif
    input  logic                 br_valid,
    output logic                 br_ready,
    input  logic [2:0]           br_func3,
    input  logic [VAR_WIDTH-1:0] br_rs1,
    input  logic [VAR_WIDTH-1:0] br_rs2,
    input  logic [VAR_WIDTH-1:0] br_pc,
    input  logic [VAR_WIDTH-1:0] br_imm,
    input  logic                 br_pred_taken,
    output logic [VAR_WIDTH-1:0] cmp_rs1,
    output logic [VAR_WIDTH-1:0] cmp_rs2,
    output logic [2:0]           cmp_func3,
    input  logic                 cmp_out,
    output logic                 resolve_valid,
    output logic                 resolve_taken,
    output logic                 misalign,
    output logic                 redirect_valid,
    input  logic                 redirect_ready,
    output logic [VAR_WIDTH-1:0] redirect_pc,
    output logic                 flush
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESOLVE, S_REDIRECT} state_t;

    state_t state, state_nxt;

    logic [2:0]           func3_q;
    logic [VAR_WIDTH-1:0] rs1_q, rs2_q, pc_q, imm_q;
    logic                 pred_q;
    logic                 taken_q;
    logic [VAR_WIDTH-1:0] target_q, fall_q;
    logic                 mis_w;

    assign mis_w = taken_q && (target_q[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            func3_q  <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
            pred_q   <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            fall_q   <= '0;
        end else begin
            if (state == S_IDLE && br_valid) begin
                func3_q <= br_func3;
                rs1_q   <= br_rs1;
                rs2_q   <= br_rs2;
                pc_q    <= br_pc;
                imm_q   <= br_imm;
                pred_q  <= br_pred_taken;
            end
            // Both candidate PCs are computed here so REDIRECT only has to mux.
            if (state == S_EVAL) begin
                taken_q  <= cmp_out;
                target_q <= pc_q + imm_q;
                fall_q   <= pc_q + VAR_WIDTH'(4);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        br_ready       = 1'b0;
        cmp_rs1        = '0;
        cmp_rs2        = '0;
        cmp_func3      = 3'b000;
        resolve_valid  = 1'b0;
        resolve_taken  = 1'b0;
        misalign       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state)
            S_IDLE: begin
                br_ready = 1'b1;
                if (br_valid) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                cmp_rs1   = rs1_q;
                cmp_rs2   = rs2_q;
                cmp_func3 = func3_q;
                state_nxt = S_RESOLVE;
            end
            S_RESOLVE: begin
                resolve_valid = 1'b1;
                resolve_taken = taken_q;
                misalign      = mis_w;
                // A misaligned target is handed to trap logic rather than redirected.
                if (!mis_w && (taken_q != pred_q)) state_nxt = S_REDIRECT;
                else                               state_nxt = S_IDLE;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = taken_q ? target_q : fall_q;
                if (redirect_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign flush = redirect_valid;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (state == S_RESOLVE) stat_branches <= stat_branches + 32'd1;
            if (state == S_RESOLVE && state_nxt == S_REDIRECT)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
